// File: rtl/video_pkg.sv
// video_pkg: shared video stream constants and the RGB pixel type.
package video_pkg;
  localparam int DATA_W = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIX_COUNT = H_ACTIVE * V_ACTIVE;
  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/pix_pos_counter.sv
// pix_pos_counter: x/y position, frame count and SOF/EOF flags for a valid-qualified pixel stream.
module pix_pos_counter import video_pkg::*; #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sync,
  input  logic           dval,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           sof,
  output logic           eof,
  output logic [7:0]     frame_cnt
);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [7:0] fc_q, fc_d;
  // sync forces the current pixel to (0,0), so advancing from x/y yields (1,0) next
  always_comb begin
    x = sync ? '0 : x_q;
    y = sync ? '0 : y_q;
    sof = dval && x == '0 && y == '0;
    eof = dval && x == X_LAST && y == Y_LAST;
    x_d = !dval ? x : (x < X_LAST ? x + 1'b1 : '0);
    y_d = (!dval || x < X_LAST) ? y : (y < Y_LAST ? y + 1'b1 : '0);
    fc_d = eof ? fc_q + 8'd1 : fc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      fc_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      fc_q <= fc_d;
    end
  end
  assign frame_cnt = fc_q;
endmodule

// File: rtl/gray_to_rgb.sv
// gray_to_rgb: 2-stage gray to RGB expansion with frame position tracking.
// Define GRAY2RGB_PSEUDOCOLOR_EN to replace grey replication with a heat-map palette.
module gray_to_rgb import video_pkg::*; #(
  parameter int DATA_W = video_pkg::DATA_W,
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSYNC,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic              oSOF,
  output logic              oEOF,
  output logic [7:0]        oFRAME_CNT
);
  typedef struct packed {
    logic              dval;
    logic              sof;
    logic              eof;
    logic [DATA_W-1:0] gray;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
  } s1_t;
  typedef struct packed {
    logic           dval;
    logic           sof;
    logic           eof;
    rgb_t           rgb;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [7:0]     fc;
  } s2_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  rgb_t rgb;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic pos_sof, pos_eof;
  logic [7:0] frame_cnt;
`ifdef GRAY2RGB_PSEUDOCOLOR_EN
  logic [1:0] seg;
  logic [DATA_W-1:0] f;
`endif
  pix_pos_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_pos (
    .clk(iCLK),
    .rst(iRST),
    .sync(iSYNC),
    .dval(iDVAL),
    .x(pos_x),
    .y(pos_y),
    .sof(pos_sof),
    .eof(pos_eof),
    .frame_cnt(frame_cnt)
  );
  // frame_cnt already reflects an EOF in stage 1, so sampling it here aligns it with that EOF output
  always_comb begin
    s1_d = s1_t'{dval: iDVAL, sof: pos_sof, eof: pos_eof, gray: iDATA, x: pos_x, y: pos_y};
`ifdef GRAY2RGB_PSEUDOCOLOR_EN
    seg = s1_q.gray[DATA_W-1 -: 2];
    f = {s1_q.gray[DATA_W-3:0], s1_q.gray[DATA_W-3 -: 2]};
    rgb = seg == 2'd0 ? rgb_t'{r: '0, g: f, b: '1} :
          seg == 2'd1 ? rgb_t'{r: '0, g: '1, b: ~f} :
          seg == 2'd2 ? rgb_t'{r: f, g: '1, b: '0} :
                        rgb_t'{r: '1, g: ~f, b: '0};
`else
    rgb = rgb_t'{r: s1_q.gray, g: s1_q.gray, b: s1_q.gray};
`endif
    s2_d = s2_t'{dval: s1_q.dval, sof: s1_q.sof, eof: s1_q.eof,
                 rgb: s1_q.dval ? rgb : s2_q.rgb,
                 x: s1_q.dval ? s1_q.x : s2_q.x,
                 y: s1_q.dval ? s1_q.y : s2_q.y,
                 fc: frame_cnt};
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign oDVAL = s2_q.dval;
  assign oRed = s2_q.rgb.r;
  assign oGreen = s2_q.rgb.g;
  assign oBlue = s2_q.rgb.b;
  assign oX = s2_q.x;
  assign oY = s2_q.y;
  assign oSOF = s2_q.sof;
  assign oEOF = s2_q.eof;
  assign oFRAME_CNT = s2_q.fc;
endmodule
